// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: boot-loader state encoding, frame constants
// and default memory geometry used by the loader and the core memory.
package mips32_pkg;

    localparam int DEPTH_DEF  = 1024;
    localparam int ADDR_W_DEF = 10;
    localparam int HDR_BYTES  = 4;
    localparam int BCNT_W     = $clog2(HDR_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } ld_state_e;

    function automatic logic is_stream(input ld_state_e s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/mips32_byte_packer.sv
// Big-endian byte-to-word packer: counts accepted bytes and flags the
// 4th byte of each word, presenting the completed word alongside it.
module mips32_byte_packer
    import mips32_pkg::*;
(
    input  logic        clk1,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic [23:0]       sh_q, sh_d;

    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (clr) begin
            cnt_d = '0;
            sh_d  = '0;
        end else if (byte_en) begin
            cnt_d = cnt_q + 1'b1;
            sh_d  = {sh_q[15:0], byte_in};
        end
    end

    // The completed word is visible in the cycle its last byte transfers,
    // so the consumer can register the result on that same edge.
    assign word_valid = byte_en && !clr &&
                        (cnt_q == BCNT_W'(HDR_BYTES - 1));
    assign word       = {sh_q, byte_in};

    always_ff @(posedge clk1) begin
        if (rst) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/mips32_boot_loader.sv
// Program-image loader: parses LEN | payload | CSUM byte frames, writes
// payload words to consecutive addresses and releases the core on success.
module mips32_boot_loader
    import mips32_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    ld_state_e         state_q, state_d;
    logic              s_ready_q, s_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_run_q, cpu_run_d;
    logic              load_err_q, load_err_d;
    logic [ADDR_W:0]   wl_q, wl_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [31:0]       csum_q, csum_d;

    logic              accept;
    logic              start_ok;
    logic              word_valid;
    logic [31:0]       word;
    logic [ADDR_W:0]   wl_inc;

    assign accept   = s_valid && s_ready_q;
    assign start_ok = start && !is_stream(state_q);
    assign wl_inc   = wl_q + 1'b1;

    mips32_byte_packer u_packer (
        .clk1       (clk1),
        .rst        (rst),
        .clr        (start_ok),
        .byte_en    (accept),
        .byte_in    (s_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_run_d   = cpu_run_q;
        load_err_d  = load_err_q;
        wl_d        = wl_q;
        len_d       = len_q;
        csum_d      = csum_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_LEN;
                    cpu_run_d  = 1'b0;
                    load_err_d = 1'b0;
                    wl_d       = '0;
                    mem_addr_d = '0;
                    csum_d     = '0;
                end
            end
            ST_LEN: begin
                if (word_valid) begin
                    len_d = word[ADDR_W:0];
                    if (word > 32'(DEPTH)) begin
                        state_d    = ST_ERR;
                        load_err_d = 1'b1;
                    end else if (word == '0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wl_q[ADDR_W-1:0];
                    mem_wdata_d = word;
                    csum_d      = csum_q + word;
                    wl_d        = wl_inc;
                    if (wl_inc == len_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (word_valid) begin
                    if (word == csum_q) begin
                        state_d   = ST_DONE;
                        cpu_run_d = 1'b1;
                    end else begin
                        state_d    = ST_ERR;
                        load_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Ready is registered alongside the state it belongs to.
        s_ready_d = is_stream(state_d);
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s_ready_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_run_q   <= 1'b0;
            load_err_q  <= 1'b0;
            wl_q        <= '0;
            len_q       <= '0;
            csum_q      <= '0;
        end else begin
            state_q     <= state_d;
            s_ready_q   <= s_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_run_q   <= cpu_run_d;
            load_err_q  <= load_err_d;
            wl_q        <= wl_d;
            len_q       <= len_d;
            csum_q      <= csum_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_run      = cpu_run_q;
    assign load_err     = load_err_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_mips32_boot_loader.sv
// Directed bench for mips32_boot_loader with a write scoreboard and
// a per-cycle check of write-strobe timing.
module tb_mips32_boot_loader;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_run;
    logic        load_err;
    logic [10:0] words_loaded;

    int          total = 0;
    int          bad   = 0;
    logic        pend  = 1'b0;
    logic        mon_en = 1'b0;
    logic [41:0] sbq[$];
    logic [31:0] pay[$];
    int          addr_m;
    logic [31:0] sum_m;

    mips32_boot_loader dut (
        .clk1         (clk1),
        .rst          (rst),
        .start        (start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_run      (cpu_run),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk1 = ~clk1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: strobe must match the bench's own expectation each
    // cycle, and each write must match the next scoreboard entry.
    always @(negedge clk1) begin
        if (!rst && mon_en) begin
            logic [41:0] e;
            check("we_timing", 64'(mem_we), 64'(pend));
            pend = 1'b0;
            if (mem_we) begin
                check("sb_avail", 64'(sbq.size() != 0), 64'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(e[41:32]));
                    check("wr_data", 64'(mem_wdata), 64'(e[31:0]));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap,
                             output bit ok);
        bit rdy;
        ok = 1'b0;
        repeat (gap) begin
            s_valid = 1'b0;
            @(posedge clk1);
            #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk1);
            rdy = s_ready;
            @(posedge clk1);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        if (!ok) check("byte_accept", 64'(ok), 64'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit is_data,
                             input int gap);
        bit ok;
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8], gap, ok);
            if (is_data && i == 3 && ok) begin
                sbq.push_back({addr_m[9:0], w});
                addr_m++;
                sum_m = sum_m + w;
                pend  = 1'b1;
            end
        end
    endtask

    task automatic send_frame(input int gap, input logic [31:0] csum_x);
        addr_m = 0;
        sum_m  = '0;
        send_word(32'(pay.size()), 1'b0, gap);
        foreach (pay[i]) send_word(pay[i], 1'b1, gap);
        send_word(sum_m ^ csum_x, 1'b0, gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk1);
        #1;
        start = 1'b0;
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_s_ready"},  64'(s_ready), 64'd0);
        check({tag, "_mem_we"},   64'(mem_we), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_wdata"},    64'(mem_wdata), 64'd0);
        check({tag, "_cpu_run"},  64'(cpu_run), 64'd0);
        check({tag, "_load_err"}, 64'(load_err), 64'd0);
        check({tag, "_words"},    64'(words_loaded), 64'd0);
    endtask

    initial begin
        bit ok;
        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (2) @(posedge clk1);
        #1;
        start = 1'b1;
        @(posedge clk1);
        #1;
        start = 1'b0;
        @(negedge clk1);
        check_outs_zero("reset");
        @(posedge clk1);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // 1: N=2 good load
        pay = '{32'h2801000A, 32'hFC000000};
        pulse_start();
        send_frame(0, 32'h0);
        @(negedge clk1);
        check("t1_cpu_run", 64'(cpu_run), 64'd1);
        check("t1_load_err", 64'(load_err), 64'd0);
        check("t1_words", 64'(words_loaded), 64'd2);
        check("t1_s_ready", 64'(s_ready), 64'd0);
        check("t1_sb_empty", 64'(sbq.size()), 64'd0);

        // 2: bad checksum
        pulse_start();
        send_frame(0, 32'h1);
        @(negedge clk1);
        check("t2_load_err", 64'(load_err), 64'd1);
        check("t2_cpu_run", 64'(cpu_run), 64'd0);
        check("t2_words", 64'(words_loaded), 64'd2);

        // 3: length too large
        pulse_start();
        send_word(32'h00000401, 1'b0, 0);
        @(negedge clk1);
        check("t3_load_err", 64'(load_err), 64'd1);
        check("t3_s_ready", 64'(s_ready), 64'd0);
        check("t3_cpu_run", 64'(cpu_run), 64'd0);
        check("t3_words", 64'(words_loaded), 64'd0);
        repeat (4) @(posedge clk1);
        #1;

        // 4: bubbles every other cycle
        pulse_start();
        send_frame(1, 32'h0);
        @(negedge clk1);
        check("t4_cpu_run", 64'(cpu_run), 64'd1);
        check("t4_words", 64'(words_loaded), 64'd2);

        // 5: reset mid-load, then full reload
        pulse_start();
        addr_m = 0;
        sum_m  = '0;
        send_word(32'h2, 1'b0, 0);
        send_byte(8'h28, 0, ok);
        send_byte(8'h01, 0, ok);
        rst = 1'b1;
        @(posedge clk1);
        #1;
        @(negedge clk1);
        check_outs_zero("t5_rst");
        @(posedge clk1);
        #1;
        rst = 1'b0;
        pulse_start();
        send_frame(0, 32'h0);
        @(negedge clk1);
        check("t5_cpu_run", 64'(cpu_run), 64'd1);
        check("t5_words", 64'(words_loaded), 64'd2);

        // 6: empty image, then restart drops cpu_run
        pay.delete();
        pulse_start();
        send_frame(0, 32'h0);
        @(negedge clk1);
        check("t6_cpu_run", 64'(cpu_run), 64'd1);
        check("t6_load_err", 64'(load_err), 64'd0);
        check("t6_words", 64'(words_loaded), 64'd0);
        @(posedge clk1);
        #1;
        pulse_start();
        @(negedge clk1);
        check("t6_restart_run", 64'(cpu_run), 64'd0);
        check("t6_restart_rdy", 64'(s_ready), 64'd1);

        repeat (3) @(posedge clk1);
        #1;
        check("final_sb_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
